// File: rtl/cp0_timer_irq.sv
// CP0 Count/Compare/Status/Cause block: prescaled timer, synchronised hardware
// interrupt lines and a registered interrupt request for the MEM/WB exception unit.

module cp0_irq_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] sync_pipe;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_pipe <= '0;
    end else begin
      sync_pipe[0] <= d;
      for (int i = 1; i < STAGES; i++) sync_pipe[i] <= sync_pipe[i-1];
    end
  end

  assign q = sync_pipe[STAGES-1];
endmodule

module cp0_timer_irq #(
  parameter int N_HW_IRQ    = 6,
  parameter int COUNT_DIV   = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                wen,
  input  logic [4:0]          reg_num,
  input  logic [1:0]          sel,
  input  logic [31:0]         reg_in,
  output logic [31:0]         reg_out,
  input  logic [N_HW_IRQ-1:0] hw_int,
  input  logic                exception_commit,
  input  logic                eret_commit,
  output logic                int_pending,
  output logic                timer_int,
  output logic [31:0]         count_out
);
  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_STATUS  = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam int         DIV_W       = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);

  typedef struct packed {
    logic count;
    logic compare;
    logic status;
    logic cause;
  } wr_dec_t;

  wr_dec_t           wr;
  logic [31:0]       count;
  logic [31:0]       compare;
  logic [DIV_W-1:0]  div_cnt;
  logic [7:0]        im;
  logic              exl;
  logic              ie;
  logic              ti;
  logic              ti_nxt;
  logic [7:0]        ip;
  logic [7:0]        ip_nxt;
  logic [5:0]        hw_ip;
  logic              match;
  logic              match_d;
  logic [N_HW_IRQ-1:0] sync_q;

  // Non-zero selects never write anything.
  always_comb begin
    wr = '0;
    if (wen && (sel == 2'd0)) begin
      wr.count   = (reg_num == REG_COUNT);
      wr.compare = (reg_num == REG_COMPARE);
      wr.status  = (reg_num == REG_STATUS);
      wr.cause   = (reg_num == REG_CAUSE);
    end
  end

  if (SYNC_STAGES == 0) begin : g_nosync
    assign sync_q = hw_int;
  end else begin : g_sync
    for (genvar k = 0; k < N_HW_IRQ; k++) begin : g_lane
      cp0_irq_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (hw_int[k]),
        .q      (sync_q[k])
      );
    end
  end

  // A COUNT write restarts the prescaler phase so the next tick is a full period away.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count   <= '0;
      div_cnt <= '0;
    end else if (wr.count) begin
      count   <= reg_in;
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      count   <= count + 32'd1;
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  assign match  = (count == compare);
  assign ti_nxt = wr.compare ? 1'b0 : (ti | (match & ~match_d));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      compare <= 32'hFFFF_FFFF;
      ti      <= 1'b0;
      match_d <= 1'b0;
    end else begin
      match_d <= match;
      ti      <= ti_nxt;
      if (wr.compare) compare <= reg_in;
    end
  end

  always_comb begin
    hw_ip = '0;
    for (int k = 0; k < N_HW_IRQ; k++) hw_ip[k] = sync_q[k];
  end

  // IP[7] tracks the next TI so the timer shows up in IP the same cycle TI does.
  assign ip_nxt = {hw_ip[5] | ti_nxt, hw_ip[4:0], wr.cause ? reg_in[9:8] : ip[1:0]};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) ip <= '0;
    else         ip <= ip_nxt;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      im  <= '0;
      ie  <= 1'b0;
      exl <= 1'b0;
    end else begin
      if (wr.status) begin
        im <= reg_in[15:8];
        ie <= reg_in[0];
      end
      if (exception_commit)  exl <= 1'b1;
      else if (eret_commit)  exl <= 1'b0;
      else if (wr.status)    exl <= reg_in[1];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) int_pending <= 1'b0;
    else         int_pending <= ie & ~exl & (|(ip & im));
  end

  always_comb begin
    reg_out = '0;
    if (sel == 2'd0) begin
      case (reg_num)
        REG_COUNT:   reg_out = count;
        REG_COMPARE: reg_out = compare;
        REG_STATUS:  reg_out = {9'd0, 1'b1, 6'd0, im, 6'd0, exl, ie};
        REG_CAUSE:   reg_out = {1'b0, ti, 14'd0, ip, 8'd0};
        default:     reg_out = '0;
      endcase
    end
  end

  assign count_out = count;
  assign timer_int = ti;
endmodule
